ne16_loop_sequencer: RTL and testbench

Hardware nested-loop index/offset sequencer for the NE16 control path: the responder side of the controller's `enable`/`ready` -> `valid`/`idx`/`idx_update`/`done`/`offs` loop-stepping handshake. Each accepted step request advances a 4-level nested counter (innermost = loop 0). It also updates per-stream base-address offsets by adding software-precomputed per-loop jump values. It is a direct-configured alternative to the microcoded uloop, sitting between the NE16 register file (config) and the control FSM.

---
 rtl/ne16_loop_sequencer_pkg.sv | 36 +++
 rtl/ne16_loop_sequencer_counter.sv | 38 +++
 rtl/ne16_loop_sequencer.sv | 139 +++++++++++++
 tb/tb_ne16_loop_sequencer.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ne16_loop_sequencer_pkg.sv
// Shared types and constants for the NE16 nested-loop index/offset sequencer.
// Streams and per-loop vectors are packed with element 0 at the LSBs.
package ne16_loop_sequencer_pkg;

  localparam int unsigned NE16_LOOPSEQ_NB_LOOPS   = 4;
  localparam int unsigned NE16_LOOPSEQ_CNT_WIDTH  = 16;
  localparam int unsigned NE16_LOOPSEQ_NB_OFFS    = 4;
  localparam int unsigned NE16_LOOPSEQ_OFFS_WIDTH = 32;

  // Offset stream slots: weights, input features, output features, scale
  localparam int unsigned NE16_LOOPSEQ_OFFS_W = 0;
  localparam int unsigned NE16_LOOPSEQ_OFFS_X = 1;
  localparam int unsigned NE16_LOOPSEQ_OFFS_Y = 2;
  localparam int unsigned NE16_LOOPSEQ_OFFS_S = 3;

  typedef enum logic [1:0] {
    LOOPSEQ_IDLE  = 2'd0,
    LOOPSEQ_VALID = 2'd1,
    LOOPSEQ_DONE  = 2'd2
  } loopseq_state_e;

  typedef struct packed {
    logic enable;
    logic ready;
    logic clear;
  } ctrl_loopseq_t;

  typedef struct packed {
    logic                                                                valid;
    logic                                                                done;
    logic [NE16_LOOPSEQ_NB_LOOPS-1:0][NE16_LOOPSEQ_CNT_WIDTH-1:0]        idx;
    logic [NE16_LOOPSEQ_NB_LOOPS-1:0]                                    idx_update;
    logic [NE16_LOOPSEQ_NB_OFFS-1:0][NE16_LOOPSEQ_OFFS_WIDTH-1:0]        offs;
  } flags_loopseq_t;

endpackage

// File: rtl/ne16_loop_sequencer_counter.sv
// One nested-loop index register; reports when it sits on its final iteration.
// A zero range behaves like a single-iteration loop.
module ne16_loopseq_counter #(
  parameter int unsigned CNT_WIDTH = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 clear_i,
  input  logic                 wrap_i,
  input  logic                 inc_i,
  input  logic [CNT_WIDTH-1:0] range_i,
  output logic [CNT_WIDTH-1:0] idx_o,
  output logic                 last_o
);

  localparam logic [CNT_WIDTH-1:0] CntOne = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  logic [CNT_WIDTH-1:0] idx_q;
  logic [CNT_WIDTH-1:0] rangeEff;

  always_comb begin
    rangeEff = (range_i == '0) ? CntOne : range_i;
    last_o   = (idx_q >= (rangeEff - CntOne));
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      idx_q <= '0;
    end else if (clear_i || wrap_i) begin
      idx_q <= '0;
    end else if (inc_i) begin
      idx_q <= idx_q + CntOne;
    end
  end

  assign idx_o = idx_q;

endmodule

// File: rtl/ne16_loop_sequencer.sv
// Direct-configured 4-level loop sequencer: steps nested indices on each
// accepted enable/ready request and accumulates per-stream offset jumps.
module ne16_loop_sequencer
  import ne16_loop_sequencer_pkg::*;
#(
  parameter int unsigned NB_LOOPS   = 4,
  parameter int unsigned CNT_WIDTH  = 16,
  parameter int unsigned NB_OFFS    = 4,
  parameter int unsigned OFFS_WIDTH = 32
) (
  input  logic                                   clk_i,
  input  logic                                   rst_ni,
  input  logic                                   clear_i,
  input  logic                                   enable_i,
  input  logic                                   ready_i,
  input  logic [NB_LOOPS*CNT_WIDTH-1:0]          range_i,
  input  logic [NB_LOOPS*NB_OFFS*OFFS_WIDTH-1:0] jump_i,
  output logic                                   valid_o,
  output logic                                   done_o,
  output logic [NB_LOOPS*CNT_WIDTH-1:0]          idx_o,
  output logic [NB_LOOPS-1:0]                    idx_update_o,
  output logic [NB_OFFS*OFFS_WIDTH-1:0]          offs_o
);

  localparam int unsigned JumpRowW = NB_OFFS * OFFS_WIDTH;

  ctrl_loopseq_t                 ctrl;
  loopseq_state_e                state_q;
  logic                          valid_q;
  logic                          done_q;
  logic [NB_LOOPS-1:0]           idxUpdate_q;
  logic [NB_LOOPS-1:0]           idxUpdate_d;
  logic [NB_OFFS*OFFS_WIDTH-1:0] offs_q;
  logic [NB_OFFS*OFFS_WIDTH-1:0] offs_d;

  logic [NB_LOOPS-1:0]           lastVec;
  logic [NB_LOOPS-1:0]           lowerAllLast;
  logic [NB_LOOPS-1:0]           wrapVec;
  logic [NB_LOOPS-1:0]           incVec;
  logic                          terminal;
  logic                          accept;
  logic [JumpRowW-1:0]           jumpSel;

  assign ctrl = '{enable: enable_i, ready: ready_i, clear: clear_i};

  assign accept = (state_q == LOOPSEQ_IDLE) & ctrl.enable & ctrl.ready &
                  ~done_q & ~ctrl.clear;

  // Carry chain: a loop moves only when every inner loop is on its last point
  always_comb begin
    lowerAllLast    = '0;
    lowerAllLast[0] = 1'b1;
    for (int l = 1; l < NB_LOOPS; l++) begin
      lowerAllLast[l] = lowerAllLast[l-1] & lastVec[l-1];
    end
    wrapVec     = lastVec & lowerAllLast;
    incVec      = ~lastVec & lowerAllLast;
    terminal    = &lastVec;
    idxUpdate_d = wrapVec | incVec;
  end

  always_comb begin
    jumpSel = '0;
    for (int l = 0; l < NB_LOOPS; l++) begin
      if (incVec[l]) begin
        jumpSel = jump_i[l*JumpRowW +: JumpRowW];
      end
    end
  end

  always_comb begin
    offs_d = '0;
    for (int o = 0; o < NB_OFFS; o++) begin
      offs_d[o*OFFS_WIDTH +: OFFS_WIDTH] = terminal ? '0 :
          offs_q[o*OFFS_WIDTH +: OFFS_WIDTH] + jumpSel[o*OFFS_WIDTH +: OFFS_WIDTH];
    end
  end

  for (genvar l = 0; l < NB_LOOPS; l++) begin : gen_loop
    ne16_loopseq_counter #(
      .CNT_WIDTH (CNT_WIDTH)
    ) u_counter (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .clear_i (clear_i),
      .wrap_i  (accept & wrapVec[l]),
      .inc_i   (accept & incVec[l]),
      .range_i (range_i[l*CNT_WIDTH +: CNT_WIDTH]),
      .idx_o   (idx_o[l*CNT_WIDTH +: CNT_WIDTH]),
      .last_o  (lastVec[l])
    );
  end

  // VALID always lasts one cycle, so a held enable cannot double-step
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= LOOPSEQ_IDLE;
      valid_q     <= 1'b0;
      done_q      <= 1'b0;
      idxUpdate_q <= '0;
      offs_q      <= '0;
    end else if (ctrl.clear) begin
      state_q     <= LOOPSEQ_IDLE;
      valid_q     <= 1'b0;
      done_q      <= 1'b0;
      idxUpdate_q <= '0;
      offs_q      <= '0;
    end else begin
      case (state_q)
        LOOPSEQ_IDLE: begin
          if (accept) begin
            state_q     <= LOOPSEQ_VALID;
            valid_q     <= 1'b1;
            done_q      <= terminal;
            idxUpdate_q <= idxUpdate_d;
            offs_q      <= offs_d;
          end
        end
        LOOPSEQ_VALID: begin
          valid_q <= 1'b0;
          state_q <= done_q ? LOOPSEQ_DONE : LOOPSEQ_IDLE;
        end
        LOOPSEQ_DONE: begin
          valid_q <= 1'b0;
        end
        default: begin
          state_q <= LOOPSEQ_IDLE;
          valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign valid_o      = valid_q;
  assign done_o       = done_q;
  assign idx_update_o = idxUpdate_q;
  assign offs_o       = offs_q;

endmodule

// File: tb/tb_ne16_loop_sequencer.sv
// Self-checking bench for ne16_loop_sequencer: a table of single steps with
// hand-computed results, plus directed handshake, clear and reset sequences.
module tb_ne16_loop_sequencer;

  localparam int NB_LOOPS   = 4;
  localparam int CNT_WIDTH  = 16;
  localparam int NB_OFFS    = 4;
  localparam int OFFS_WIDTH = 32;

  logic                                   clk_i = 1'b0;
  logic                                   rst_ni = 1'b0;
  logic                                   clear_i = 1'b0;
  logic                                   enable_i = 1'b0;
  logic                                   ready_i = 1'b0;
  logic [NB_LOOPS*CNT_WIDTH-1:0]          range_i;
  logic [NB_LOOPS*NB_OFFS*OFFS_WIDTH-1:0] jump_i;
  logic                                   valid_o;
  logic                                   done_o;
  logic [NB_LOOPS*CNT_WIDTH-1:0]          idx_o;
  logic [NB_LOOPS-1:0]                    idx_update_o;
  logic [NB_OFFS*OFFS_WIDTH-1:0]          offs_o;

  int nChecks = 0;
  int nFails  = 0;

  typedef struct {
    logic        clearFirst;
    logic [15:0] r0, r1;
    logic [31:0] j00, j10, j01, j11;
    logic [15:0] eIdx0, eIdx1;
    logic [3:0]  eUpd;
    logic [31:0] eOffs0, eOffs1;
    logic        eDone;
  } vec_t;

  vec_t vecs[13];

  ne16_loop_sequencer #(
    .NB_LOOPS   (NB_LOOPS),
    .CNT_WIDTH  (CNT_WIDTH),
    .NB_OFFS    (NB_OFFS),
    .OFFS_WIDTH (OFFS_WIDTH)
  ) u_dut (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .clear_i      (clear_i),
    .enable_i     (enable_i),
    .ready_i      (ready_i),
    .range_i      (range_i),
    .jump_i       (jump_i),
    .valid_o      (valid_o),
    .done_o       (done_o),
    .idx_o        (idx_o),
    .idx_update_o (idx_update_o),
    .offs_o       (offs_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic checkOutput(input string name, input logic [127:0] actual,
                             input logic [127:0] expected);
    nChecks++;
    if (actual !== expected) begin
      nFails++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  // Loops 2/3 have range 1 and carry junk jumps that must never be added
  task automatic setConfig(input logic [15:0] r0, input logic [15:0] r1,
                           input logic [31:0] j00, input logic [31:0] j10,
                           input logic [31:0] j01, input logic [31:0] j11);
    range_i             = {16'd1, 16'd1, r1, r0};
    jump_i              = '0;
    jump_i[0   +: 32]   = j00;
    jump_i[32  +: 32]   = j01;
    jump_i[128 +: 32]   = j10;
    jump_i[160 +: 32]   = j11;
    jump_i[256 +: 128]  = {4{32'hDEAD_0001}};
    jump_i[384 +: 128]  = {4{32'h0BAD_0003}};
  endtask

  task automatic applyStimulus(output bit seen);
    @(negedge clk_i);
    enable_i = 1'b1;
    ready_i  = 1'b1;
    seen     = 1'b0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk_i);
      if (valid_o) begin
        seen = 1'b1;
        break;
      end
    end
    enable_i = 1'b0;
    ready_i  = 1'b0;
  endtask

  task automatic doClear();
    @(negedge clk_i);
    clear_i = 1'b1;
    @(negedge clk_i);
    clear_i = 1'b0;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    bit seen;
    bit sawValid;

    // ranges {0,2}: every step wraps loop 0 and bumps loop 1
    vecs[0]  = '{1'b1, 16'd0, 16'd2, 32'd5, 32'd9, 32'd0, 32'd6, 16'd0, 16'd1, 4'b0011, 32'd9, 32'd6, 1'b0};
    vecs[1]  = '{1'b0, 16'd0, 16'd2, 32'd5, 32'd9, 32'd0, 32'd6, 16'd0, 16'd0, 4'b1111, 32'd0, 32'd0, 1'b1};
    // offset arithmetic wraps modulo 2^32
    vecs[2]  = '{1'b1, 16'd2, 16'd2, 32'hFFFF_FFFF, 32'd2, 32'd1, 32'd0, 16'd1, 16'd0, 4'b0001, 32'hFFFF_FFFF, 32'd1, 1'b0};
    vecs[3]  = '{1'b0, 16'd2, 16'd2, 32'hFFFF_FFFF, 32'd2, 32'd1, 32'd0, 16'd0, 16'd1, 4'b0011, 32'd1, 32'd1, 1'b0};
    vecs[4]  = '{1'b0, 16'd2, 16'd2, 32'hFFFF_FFFF, 32'd2, 32'd1, 32'd0, 16'd1, 16'd1, 4'b0001, 32'd0, 32'd2, 1'b0};
    // ranges {2,3}, full job of six steps ending in DONE
    vecs[5]  = '{1'b1, 16'd2, 16'd3, 32'd4, 32'd100, 32'd7, 32'd3, 16'd1, 16'd0, 4'b0001, 32'd4,   32'd7,  1'b0};
    vecs[6]  = '{1'b0, 16'd2, 16'd3, 32'd4, 32'd100, 32'd7, 32'd3, 16'd0, 16'd1, 4'b0011, 32'd104, 32'd10, 1'b0};
    vecs[7]  = '{1'b0, 16'd2, 16'd3, 32'd4, 32'd100, 32'd7, 32'd3, 16'd1, 16'd1, 4'b0001, 32'd108, 32'd17, 1'b0};
    vecs[8]  = '{1'b0, 16'd2, 16'd3, 32'd4, 32'd100, 32'd7, 32'd3, 16'd0, 16'd2, 4'b0011, 32'd208, 32'd20, 1'b0};
    vecs[9]  = '{1'b0, 16'd2, 16'd3, 32'd4, 32'd100, 32'd7, 32'd3, 16'd1, 16'd2, 4'b0001, 32'd212, 32'd27, 1'b0};
    vecs[10] = '{1'b0, 16'd2, 16'd3, 32'd4, 32'd100, 32'd7, 32'd3, 16'd0, 16'd0, 4'b1111, 32'd0,   32'd0,  1'b1};
    vecs[11] = vecs[10];
    vecs[11].clearFirst = 1'b1;
    vecs[11].eIdx0 = 16'd1; vecs[11].eUpd = 4'b0001; vecs[11].eOffs0 = 32'd4;
    vecs[11].eOffs1 = 32'd7; vecs[11].eDone = 1'b0;
    vecs[12] = vecs[6];

    setConfig(16'd2, 16'd3, 32'd4, 32'd100, 32'd7, 32'd3);
    #3;
    checkOutput("in_reset valid", valid_o, 0);
    checkOutput("in_reset idx", idx_o, 0);
    repeat (2) @(negedge clk_i);
    rst_ni = 1'b1;
    @(negedge clk_i);
    checkOutput("reset valid", valid_o, 0);
    checkOutput("reset done", done_o, 0);
    checkOutput("reset idx", idx_o, 0);
    checkOutput("reset upd", idx_update_o, 0);
    checkOutput("reset offs", offs_o, 0);

    for (int i = 0; i < 13; i++) begin
      if (vecs[i].clearFirst) doClear();
      setConfig(vecs[i].r0, vecs[i].r1, vecs[i].j00, vecs[i].j10, vecs[i].j01, vecs[i].j11);
      applyStimulus(seen);
      checkOutput($sformatf("v%0d valid", i), seen, 1);
      checkOutput($sformatf("v%0d idx", i), idx_o, {32'd0, vecs[i].eIdx1, vecs[i].eIdx0});
      checkOutput($sformatf("v%0d upd", i), idx_update_o, vecs[i].eUpd);
      checkOutput($sformatf("v%0d offs", i), offs_o, {64'd0, vecs[i].eOffs1, vecs[i].eOffs0});
      checkOutput($sformatf("v%0d done", i), done_o, vecs[i].eDone);
    end

    // Finish the job started by the last two vectors, then request once more
    repeat (4) applyStimulus(seen);
    checkOutput("job end done", done_o, 1);
    @(negedge clk_i);
    enable_i = 1'b1;
    ready_i  = 1'b1;
    sawValid = 1'b0;
    repeat (6) begin
      @(negedge clk_i);
      if (valid_o) sawValid = 1'b1;
    end
    enable_i = 1'b0;
    ready_i  = 1'b0;
    checkOutput("after_done no valid", sawValid, 0);
    checkOutput("after_done done", done_o, 1);
    checkOutput("after_done idx", idx_o, 0);

    // ready held low stalls the request
    doClear();
    setConfig(16'd2, 16'd3, 32'd4, 32'd100, 32'd7, 32'd3);
    @(negedge clk_i);
    enable_i = 1'b1;
    ready_i  = 1'b0;
    sawValid = 1'b0;
    repeat (5) begin
      @(negedge clk_i);
      if (valid_o) sawValid = 1'b1;
    end
    checkOutput("stall no valid", sawValid, 0);
    checkOutput("stall idx", idx_o, 0);
    ready_i = 1'b1;
    @(negedge clk_i);
    checkOutput("stall release valid", valid_o, 1);
    checkOutput("stall release idx", idx_o, 64'd1);
    enable_i = 1'b0;
    ready_i  = 1'b0;
    @(negedge clk_i);
    checkOutput("stall pulse width", valid_o, 0);
    @(negedge clk_i);
    checkOutput("stall single step", idx_o, 64'd1);

    // enable held high: one step every other cycle
    doClear();
    setConfig(16'd8, 16'd1, 32'd1, 32'd0, 32'd0, 32'd0);
    @(negedge clk_i);
    enable_i = 1'b1;
    ready_i  = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk_i);
      checkOutput($sformatf("b2b%0d valid", i), valid_o, (i % 2 == 0) ? 1 : 0);
      if (i % 2 == 0) checkOutput($sformatf("b2b%0d idx", i), idx_o, 128'(i / 2 + 1));
    end
    enable_i = 1'b0;
    ready_i  = 1'b0;

    // clear coinciding with an accept mid-job
    doClear();
    setConfig(16'd2, 16'd3, 32'd4, 32'd100, 32'd7, 32'd3);
    repeat (5) applyStimulus(seen);
    checkOutput("midjob idx", idx_o, {32'd0, 16'd2, 16'd1});
    checkOutput("midjob offs", offs_o, {64'd0, 32'd27, 32'd212});
    @(negedge clk_i);
    enable_i = 1'b1;
    ready_i  = 1'b1;
    clear_i  = 1'b1;
    @(negedge clk_i);
    checkOutput("clr_accept valid", valid_o, 0);
    checkOutput("clr_accept idx", idx_o, 0);
    checkOutput("clr_accept offs", offs_o, 0);
    checkOutput("clr_accept upd", idx_update_o, 0);
    checkOutput("clr_accept done", done_o, 0);
    clear_i  = 1'b0;
    enable_i = 1'b0;
    ready_i  = 1'b0;
    @(negedge clk_i);
    checkOutput("clr_accept no late step", valid_o, 0);

    // async reset mid-job, taken between clock edges
    repeat (5) applyStimulus(seen);
    #2;
    rst_ni = 1'b0;
    #1;
    checkOutput("arst valid", valid_o, 0);
    checkOutput("arst idx", idx_o, 0);
    checkOutput("arst offs", offs_o, 0);
    checkOutput("arst upd", idx_update_o, 0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    @(negedge clk_i);
    checkOutput("arst after idx", idx_o, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
